// File: rtl/dct_transpose_buffer_if.sv
// Row/column stream bundle between the row DCT, the transpose buffer and the
// column DCT.
// The "slave" modport is the buffer side: it accepts rows and offers columns.
// The "master" modport is the surrounding pipeline side.
interface dct_transpose_buffer_if #(
    parameter int W = 18
);
    // Row side: one W x 8 row of row-DCT coefficients per transfer.
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_row [7:0];

    // Column side: one W x 8 transposed column per transfer.
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_col [7:0];
    logic [2:0]          out_col_idx;
    logic                out_last;

    modport slave (
        input  in_valid,
        input  in_row,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_col,
        output out_col_idx,
        output out_last
    );

    modport master (
        output in_valid,
        output in_row,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_col,
        input  out_col_idx,
        input  out_last
    );
endinterface

// File: rtl/dct_transpose_buffer.sv
// 8x8 transpose buffer between the row DCT and the column DCT.
// Rows are written whole into a bank; once the bank holds 8 rows it is read
// back one column per transfer, column 0 first.
// Build option TRANSPOSE_PINGPONG_EN: when defined, two banks are used so a
// block can be filled while the previous one drains; when undefined, a single
// bank is used and the row side stalls while the block drains.
module dct_transpose_buffer #(
    parameter int W     = 18,
    parameter int DEPTH = 8     // block dimension; only 8 is supported
) (
    input  logic                  clk,
    input  logic                  rst,
    dct_transpose_buffer_if.slave bus
);

`ifdef TRANSPOSE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int            CW          = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_IDX    = CW'(DEPTH - 1);
    // With one bank the pointers never move; with two they alternate.
    localparam logic          BANK_TOGGLE = 1'(NB == 2);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    bank_state_e   bank_q [NB];
    bank_state_e   bank_d [NB];
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;

    logic          in_ready;
    logic          out_valid;
    logic          wr_fire;
    logic          rd_fire;
    logic [DEPTH*W-1:0] col_flat;

    // A bank accepts rows until it is full; it offers columns once full.
    assign in_ready  = (bank_q[wr_bank_q] == BANK_EMPTY) ||
                       (bank_q[wr_bank_q] == BANK_FILLING);
    assign out_valid = (bank_q[rd_bank_q] == BANK_FULL) ||
                       (bank_q[rd_bank_q] == BANK_DRAINING);
    assign wr_fire   = bus.in_valid && in_ready;
    assign rd_fire   = out_valid && bus.out_ready;

    // Next-state for bank states, counters and bank pointers. A row write and
    // a column read can never target the same bank in one cycle, because a
    // bank is either writable or readable, never both.
    always_comb begin
        bank_d    = bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;

        for (int b = 0; b < NB; b++) begin
            if (wr_fire && (wr_bank_q == 1'(b))) begin
                bank_d[b] = (wr_cnt_q == LAST_IDX) ? BANK_FULL : BANK_FILLING;
            end
            if (rd_fire && (rd_bank_q == 1'(b))) begin
                bank_d[b] = (rd_cnt_q == LAST_IDX) ? BANK_EMPTY : BANK_DRAINING;
            end
        end

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
            if (wr_cnt_q == LAST_IDX) begin
                wr_bank_d = wr_bank_q ^ BANK_TOGGLE;
            end
        end

        if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + CW'(1);
            if (rd_cnt_q == LAST_IDX) begin
                rd_bank_d = rd_bank_q ^ BANK_TOGGLE;
            end
        end
    end

    // Control state register; reset empties every bank and wins over any
    // transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                bank_q[b] <= BANK_EMPTY;
            end
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // One storage array per row position so that a whole column (one element
    // from each row) can be read in a single cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
        logic signed [W-1:0] row_q [NB][DEPTH];

        // Capture the incoming row when it is row gi of the write bank.
        always_ff @(posedge clk) begin
            if (!rst && wr_fire && (wr_cnt_q == CW'(gi))) begin
                for (int c = 0; c < DEPTH; c++) begin
                    row_q[wr_bank_q][c] <= bus.in_row[c];
                end
            end
        end

        assign col_flat[gi*W +: W] = row_q[rd_bank_q][rd_cnt_q];
    end

    // Present the selected column; it is a pure function of registered state,
    // so it holds steady while the consumer stalls.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            bus.out_col[r] = col_flat[r*W +: W];
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_col_idx = 3'(rd_cnt_q);
    assign bus.out_last    = out_valid && (rd_cnt_q == LAST_IDX);

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed bench for dct_transpose_buffer: identity blocks, back-pressure,
// extreme-value streaming and mid-block reset. Expectations adapt to the
// TRANSPOSE_PINGPONG_EN build option.
module tb_dct_transpose_buffer;
    localparam int W = 18;
`ifdef TRANSPOSE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct_transpose_buffer_if #(.W(W)) bus ();

    dct_transpose_buffer #(.W(W), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic signed [W-1:0] blk  [8][8][8];
    logic signed [W-1:0] vals [4];

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        assert_cnt++;
        assert (got === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) bus.in_row[c] = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("reset_in_ready",  bus.in_ready,    1);
        chk("reset_out_valid", bus.out_valid,   0);
        chk("reset_out_last",  bus.out_last,    0);
        chk("reset_col_idx",   bus.out_col_idx, 0);
        rst = 1'b0;
    endtask

    task automatic fill_ident(input int b, input int base);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[b][r][c] = W'(base + 16*r + c);
    endtask

    // Push nblk blocks from blk[] and drain them. hold keeps out_ready low
    // until every row is in; a stall of stall_len cycles is applied on column
    // stall_col of block 0. exp_edges / exp_low (total clock edges, cycles
    // with in_ready low) are checked when non-negative.
    task automatic stream(input int nblk, input bit hold, input int stall_col,
                          input int stall_len, input int exp_edges,
                          input int exp_low);
        int in_b = 0, in_r = 0, out_b = 0, out_c = 0;
        int pending = 0, edges = 0, low = 0, stall_cnt = 0;
        bit ready, wr_fire, rd_fire;
        while (out_b < nblk && edges < 600) begin
            bus.in_valid = (in_b < nblk);
            if (in_b < nblk)
                for (int c = 0; c < 8; c++) bus.in_row[c] = blk[in_b][in_r][c];
            ready = 1'b1;
            if (hold && in_b < nblk) begin
                ready = 1'b0;
            end else if (bus.out_valid && out_b == 0 && out_c == stall_col &&
                         stall_cnt < stall_len) begin
                ready = 1'b0;
                stall_cnt++;
            end
            bus.out_ready = ready;

            chk("in_ready",  bus.in_ready,  (pending < NB) ? 1 : 0);
            chk("out_valid", bus.out_valid, (pending > 0)  ? 1 : 0);
            if (bus.out_valid) begin
                chk("out_col_idx", bus.out_col_idx, out_c);
                chk("out_last",    bus.out_last,    (out_c == 7) ? 1 : 0);
                for (int r = 0; r < 8; r++)
                    chk("out_col", bus.out_col[r], blk[out_b][r][out_c]);
            end
            if (!bus.in_ready) low++;

            wr_fire = bus.in_valid && bus.in_ready;
            rd_fire = bus.out_valid && ready;
            if (rd_fire)
                $display("column blk=%0d idx=%0d last=%0b", out_b,
                         bus.out_col_idx, bus.out_last);
            if (wr_fire) begin
                if (in_r == 7) begin
                    in_r = 0;
                    in_b++;
                    pending++;
                end else begin
                    in_r++;
                end
            end
            if (rd_fire) begin
                if (out_c == 7) begin
                    out_c = 0;
                    out_b++;
                    pending--;
                end else begin
                    out_c++;
                end
            end
            @(posedge clk);
            #1;
            edges++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("blocks_out", out_b, nblk);
        if (exp_edges >= 0) chk("total_cycles", edges, exp_edges);
        if (exp_low >= 0)   chk("in_ready_low_cycles", low, exp_low);
    endtask

    initial begin
        vals[0] = 18'h20000;   // -131072
        vals[1] = 18'h1FFFF;   //  131071
        vals[2] = 18'h00000;   //  0
        vals[3] = 18'h3FFFF;   // -1

        do_reset();

        // Identity pattern, two blocks back-to-back.
        fill_ident(0, 0);
        fill_ident(1, 0);
        $display("identity x2");
        stream(2, 1'b0, -1, 0, (NB == 2) ? 24 : 32, (NB == 2) ? 0 : 16);

        // Back-pressure: fill every bank, then stall 5 cycles on column 3.
        do_reset();
        for (int b = 0; b < NB; b++) fill_ident(b, 256 + 128*b);
        $display("back-pressure");
        stream(NB, 1'b1, 3, 5, -1, -1);

        // Extreme values, four blocks streamed continuously.
        do_reset();
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    blk[b][r][c] = vals[(b + 3*r + c) % 4];
        $display("extreme streaming x4");
        stream(4, 1'b0, -1, 0, (NB == 2) ? 40 : 64, (NB == 2) ? 0 : 32);

        // Reset after 5 rows, with a row transfer offered during reset.
        do_reset();
        fill_ident(0, 768);
        bus.in_valid = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 8; c++) bus.in_row[c] = blk[0][r][c];
            chk("pre_reset_in_ready", bus.in_ready, 1);
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 8; c++) bus.in_row[c] = blk[0][5][c];
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("midrst_out_valid", bus.out_valid,   0);
        chk("midrst_in_ready",  bus.in_ready,    1);
        chk("midrst_col_idx",   bus.out_col_idx, 0);
        chk("midrst_out_last",  bus.out_last,    0);
        fill_ident(0, 1280);
        $display("post-reset block");
        stream(1, 1'b0, -1, 0, 16, (NB == 2) ? 0 : 8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_cnt, fail_cnt);
        $finish;
    end
endmodule
